branch_predictor: RTL and testbench
===================================

// Module: branch_predictor
// PURPOSE
//  Fetch-side counterpart of the EX-stage jump/branch resolver. Direct-mapped BTB
//  with 2-bit saturating counters predicts next PC in IF. The same block takes the
//  resolved outcome back from EX, updates its table and flags mispredictions.
//  The hazard unit consumes MispredictE to flush D/E and steer PC to RedirectPCE.
// PARAMETERS
//  XLEN     32  address width
//  IDX_W    4   index bits; ENTRIES = 2**IDX_W (16)
// PORTS
//  clk           in   1     clock, rising edge
//  rst           in   1     reset, asynchronous, active-high
//  PCF           in   XLEN  fetch PC (word aligned)
//  PredTakenF    out  1     predict taken for PCF
//  PredTargetF   out  XLEN  predicted target; valid when PredTakenF=1
//  UpdateE       in   1     EX holds a resolved branch/jump this cycle
//  IsJumpE       in   1     EX instr is unconditional (JAL/JALR)
//  PCE           in   XLEN  PC of EX instr
//  TakenE        in   1     actual outcome (PCSrcE != 2'b00)
//  TargetE       in   XLEN  actual target (PCTargetE or JALR ALU result)
//  PredTakenE    in   1     PredTakenF piped down to EX
//  PredTargetE   in   XLEN  PredTargetF piped down to EX
//  MispredictE   out  1     prediction wrong; flush D and E
//  RedirectPCE   out  XLEN  corrected next PC
// BEHAVIOUR
//  - Entry: valid(1), tag(XLEN-IDX_W-2), target(XLEN), ctr(2): 00 SN, 01 WN, 10 WT, 11 ST.
//  - Index = PC[IDX_W+1:2]; tag = PC[XLEN-1:IDX_W+2].
//  - IF read is combinational: hitF = valid && tag match.
//    PredTakenF = hitF && ctr[1]; PredTargetF = target when hitF, else 0.
//  - MispredictE = UpdateE && (PredTakenE != TakenE || (TakenE && PredTargetE != TargetE)).
//  - RedirectPCE = TakenE ? TargetE : PCE+4 (mod 2**XLEN). Both are combinational, 0 latency.
//  - Table write is on the rising edge when UpdateE=1, using the entry at PCE's index.
//  - Miss, TakenE=1: allocate/replace. valid=1, tag, target=TargetE, ctr = IsJumpE ? 11 : 10.
//  - Miss, TakenE=0: no write.
//  - Hit, IsJumpE=1: ctr=11, target=TargetE.
//  - Hit, TakenE=1: ctr=sat_inc (11 stays 11), target=TargetE.
//  - Hit, TakenE=0: ctr=sat_dec (00 stays 00); target unchanged.
//  - UpdateE=0: table unchanged; PredTakenE/TargetE/IsJumpE ignored; MispredictE=0.
//  - Same-index IF read and EX write in one cycle: IF sees the old contents. No bypass.
//  - Tag aliasing on the index is resolved by replacement only. No associativity.
//  - Reset (async, any time, including mid-update): all valid=0, ctr=01, target=0, tag=0.
//    During and after reset: PredTakenF=0, PredTargetF=0. MispredictE and RedirectPCE
//    follow their inputs.
//  - Writes are ignored while rst=1. First write is on the first edge after rst falls.
// CONFIGURATION
//  BP_STATS_EN defined: adds outputs BranchCntE[31:0] and MispredCntE[31:0], reset 0.
//    Each edge with UpdateE=1 increments BranchCntE.
//    MispredCntE increments when MispredictE=1 on that edge. Both wrap at 2**32.
//  BP_STATS_EN undefined: those ports and their registers do not exist. All other
//    behaviour is identical.
// TESTING
//  1) Reset, PCF=0x100 -> PredTakenF=0, PredTargetF=0.
//  2) Taken branch miss: UpdateE, PCE=0x100, TakenE=1, TargetE=0x80, PredTakenE=0
//     -> MispredictE=1, RedirectPCE=0x80. Next cycle PCF=0x100 -> PredTakenF=1, PredTargetF=0x80.
//  3) Then two not-taken updates at 0x100 (ctr 10->01->00). First: MispredictE=1,
//     RedirectPCE=0x104. Afterwards PredTakenF=0.
//     A third not-taken update leaves ctr=00.
//  4) Alias: allocate 0x100, then taken update at 0x140 (same index, IDX_W=4)
//     -> PCF=0x100 misses; PCF=0x140 predicts its own target.
//  5) Jump with wrong target: hit at PCE, IsJumpE=1, PredTakenE=1,
//     PredTargetE=0x200, TargetE=0x300 -> MispredictE=1, RedirectPCE=0x300; entry target=0x300.
//  6) Assert rst mid-run with entries valid -> PredTakenF=0 with no clock edge.
//     With BP_STATS_EN, both counters read 0.

Source files
------------

// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
//
// Fetch-side branch predictor paired with the EX-stage branch/jump resolver.
// A direct-mapped branch target buffer (BTB) with 2-bit saturating counters
// predicts the next PC during IF. The resolved outcome comes back from EX. It
// updates the table and raises a misprediction flag that the hazard unit uses
// to flush D/E and to steer the PC to RedirectPCE.
//
// Parameters
//   XLEN   address width
//   IDX_W  index bits; the table has 2**IDX_W entries
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   asynchronous, active-high reset (clears the table)
//   PCF          in   fetch PC (word aligned)
//   PredTakenF   out  predict taken for PCF
//   PredTargetF  out  predicted target; valid when PredTakenF=1 (0 on a miss)
//   UpdateE      in   EX holds a resolved branch/jump this cycle
//   IsJumpE      in   EX instruction is unconditional (JAL/JALR)
//   PCE          in   PC of the EX instruction
//   TakenE       in   actual outcome
//   TargetE      in   actual target
//   PredTakenE   in   PredTakenF piped down to EX
//   PredTargetE  in   PredTargetF piped down to EX
//   MispredictE  out  prediction was wrong; flush D and E
//   RedirectPCE  out  corrected next PC
//
// Optional feature (macro BP_STATS_EN)
//   When defined, this block adds the outputs BranchCntE[31:0] and
//   MispredCntE[31:0]. They count resolved updates and mispredictions. Both
//   reset to 0 and wrap.
// -----------------------------------------------------------------------------
module branch_predictor #(
    parameter int XLEN  = 32,
    parameter int IDX_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] PCF,
    output logic            PredTakenF,
    output logic [XLEN-1:0] PredTargetF,
    input  logic            UpdateE,
    input  logic            IsJumpE,
    input  logic [XLEN-1:0] PCE,
    input  logic            TakenE,
    input  logic [XLEN-1:0] TargetE,
    input  logic            PredTakenE,
    input  logic [XLEN-1:0] PredTargetE,
    output logic            MispredictE,
`ifdef BP_STATS_EN
    output logic [XLEN-1:0] RedirectPCE,
    output logic [31:0]     BranchCntE,
    output logic [31:0]     MispredCntE
`else
    output logic [XLEN-1:0] RedirectPCE
`endif
);

    localparam int ENTRIES = 2 ** IDX_W;
    localparam int TAG_W   = XLEN - IDX_W - 2;

    // Counter encodings: 00 strongly not-taken ... 11 strongly taken.
    localparam logic [1:0] CTR_WN = 2'b01;
    localparam logic [1:0] CTR_WT = 2'b10;
    localparam logic [1:0] CTR_ST = 2'b11;

    function automatic logic [1:0] satInc(input logic [1:0] c);
        return (c == 2'b11) ? 2'b11 : c + 2'b01;
    endfunction

    function automatic logic [1:0] satDec(input logic [1:0] c);
        return (c == 2'b00) ? 2'b00 : c - 2'b01;
    endfunction

    logic             validQ  [ENTRIES];
    logic [TAG_W-1:0] tagQ    [ENTRIES];
    logic [XLEN-1:0]  targetQ [ENTRIES];
    logic [1:0]       ctrQ    [ENTRIES];

    logic [IDX_W-1:0] idxF, idxE;
    logic [TAG_W-1:0] tagF, tagE;
    logic             hitF, hitE;

    // The instruction-alignment bits never address the table.
    logic unusedAlignBits;
    assign unusedAlignBits = ^{PCF[1:0], PCE[1:0]};

    assign idxF = PCF[IDX_W+1:2];
    assign tagF = PCF[XLEN-1:IDX_W+2];
    assign idxE = PCE[IDX_W+1:2];
    assign tagE = PCE[XLEN-1:IDX_W+2];

    // IF lookup is purely combinational. A write in the same cycle only lands
    // on the next edge, so fetch sees the old entry (no bypass).
    assign hitF        = !rst && validQ[idxF] && (tagQ[idxF] == tagF);
    assign PredTakenF  = hitF && ctrQ[idxF][1];
    assign PredTargetF = hitF ? targetQ[idxF] : '0;

    assign hitE = validQ[idxE] && (tagQ[idxE] == tagE);

    // A wrong target counts only when the branch was actually taken. For a
    // not-taken branch, the predicted target was never used.
    assign MispredictE = UpdateE &&
                         ((PredTakenE != TakenE) || (TakenE && (PredTargetE != TargetE)));
    assign RedirectPCE = TakenE ? TargetE : PCE + XLEN'(4);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                validQ[i]  <= 1'b0;
                tagQ[i]    <= '0;
                targetQ[i] <= '0;
                ctrQ[i]    <= CTR_WN;
            end
        end else if (UpdateE) begin
            if (hitE) begin
                if (IsJumpE) begin
                    ctrQ[idxE]    <= CTR_ST;
                    targetQ[idxE] <= TargetE;
                end else if (TakenE) begin
                    ctrQ[idxE]    <= satInc(ctrQ[idxE]);
                    targetQ[idxE] <= TargetE;
                end else begin
                    ctrQ[idxE]    <= satDec(ctrQ[idxE]);
                end
            end else if (TakenE) begin
                // On a miss, allocate the entry or replace an aliasing tag. A
                // not-taken miss is not worth an entry.
                validQ[idxE]  <= 1'b1;
                tagQ[idxE]    <= tagE;
                targetQ[idxE] <= TargetE;
                ctrQ[idxE]    <= IsJumpE ? CTR_ST : CTR_WT;
            end
        end
    end

`ifdef BP_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            BranchCntE  <= '0;
            MispredCntE <= '0;
        end else if (UpdateE) begin
            BranchCntE <= BranchCntE + 32'd1;
            if (MispredictE) begin
                MispredCntE <= MispredCntE + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// -----------------------------------------------------------------------------
// tb_branch_predictor
//
// Directed testbench for branch_predictor (XLEN=32, IDX_W=4). Inputs change on
// the falling clock edge. Outputs are sampled 1 time unit later, away from the
// rising edge that writes the table.
// -----------------------------------------------------------------------------
module tb_branch_predictor;

    logic        clk;
    logic        rst;
    logic [31:0] PCF;
    logic        PredTakenF;
    logic [31:0] PredTargetF;
    logic        UpdateE;
    logic        IsJumpE;
    logic [31:0] PCE;
    logic        TakenE;
    logic [31:0] TargetE;
    logic        PredTakenE;
    logic [31:0] PredTargetE;
    logic        MispredictE;
    logic [31:0] RedirectPCE;
`ifdef BP_STATS_EN
    logic [31:0] BranchCntE;
    logic [31:0] MispredCntE;
`endif

    int errCnt   = 0;
    int checkCnt = 0;
    int expBranch  = 0;
    int expMispred = 0;

    branch_predictor #(.XLEN(32), .IDX_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .PCF         (PCF),
        .PredTakenF  (PredTakenF),
        .PredTargetF (PredTargetF),
        .UpdateE     (UpdateE),
        .IsJumpE     (IsJumpE),
        .PCE         (PCE),
        .TakenE      (TakenE),
        .TargetE     (TargetE),
        .PredTakenE  (PredTakenE),
        .PredTargetE (PredTargetE),
        .MispredictE (MispredictE),
`ifdef BP_STATS_EN
        .RedirectPCE (RedirectPCE),
        .BranchCntE  (BranchCntE),
        .MispredCntE (MispredCntE)
`else
        .RedirectPCE (RedirectPCE)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCnt++;
        if (got !== exp) begin
            errCnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One resolved update from EX. The combinational outputs are checked
    // before the writing edge.
    task automatic update(input string tag, input logic [31:0] pc, input logic isJump,
                          input logic taken, input logic [31:0] target,
                          input logic predTaken, input logic [31:0] predTarget,
                          input logic expMis, input logic [31:0] expRedir);
        @(negedge clk);
        UpdateE     = 1'b1;
        PCE         = pc;
        IsJumpE     = isJump;
        TakenE      = taken;
        TargetE     = target;
        PredTakenE  = predTaken;
        PredTargetE = predTarget;
        #1;
        checkVal({tag, ".mis"}, {31'b0, MispredictE}, {31'b0, expMis});
        checkVal({tag, ".redir"}, RedirectPCE, expRedir);
        expBranch++;
        if (expMis) expMispred++;
        @(posedge clk);
        #1;
        UpdateE = 1'b0;
    endtask

    task automatic probe(input string tag, input logic [31:0] pc,
                         input logic expTaken, input logic [31:0] expTarget);
        PCF = pc;
        #1;
        checkVal({tag, ".taken"}, {31'b0, PredTakenF}, {31'b0, expTaken});
        checkVal({tag, ".target"}, PredTargetF, expTarget);
    endtask

    initial begin
        rst = 1'b0; PCF = 32'h100; UpdateE = 1'b0; IsJumpE = 1'b0; PCE = '0;
        TakenE = 1'b0; TargetE = '0; PredTakenE = 1'b0; PredTargetE = '0;
        #2 rst = 1'b1;

        // Reset. An update presented during reset must not be written, but
        // the EX outputs still follow their inputs.
        UpdateE = 1'b1; PCE = 32'h100; TakenE = 1'b1; TargetE = 32'h80;
        @(negedge clk); #1;
        checkVal("rst.predTaken", {31'b0, PredTakenF}, 32'd0);
        checkVal("rst.predTarget", PredTargetF, 32'd0);
        checkVal("rst.mis", {31'b0, MispredictE}, 32'd1);
        checkVal("rst.redir", RedirectPCE, 32'h80);
        @(negedge clk);
        rst = 1'b0; UpdateE = 1'b0;
        #1;
        probe("postRst", 32'h100, 1'b0, 32'h0);
`ifdef BP_STATS_EN
        checkVal("postRst.branchCnt", BranchCntE, 32'd0);
        checkVal("postRst.mispredCnt", MispredCntE, 32'd0);
`endif

        // Taken miss allocates with ctr=10. This also checks that there is
        // no same-cycle bypass.
        @(negedge clk);
        UpdateE = 1'b1; PCE = 32'h100; IsJumpE = 1'b0; TakenE = 1'b1;
        TargetE = 32'h80; PredTakenE = 1'b0; PredTargetE = 32'h0; PCF = 32'h100;
        #1;
        checkVal("alloc.mis", {31'b0, MispredictE}, 32'd1);
        checkVal("alloc.redir", RedirectPCE, 32'h80);
        checkVal("alloc.noBypass", {31'b0, PredTakenF}, 32'd0);
        expBranch++; expMispred++;
        @(negedge clk);
        UpdateE = 1'b0;
        #1;
        probe("alloc.after", 32'h100, 1'b1, 32'h80);
        checkVal("idle.mis", {31'b0, MispredictE}, 32'd0);

        // Not-taken updates: 10 -> 01 -> 00 -> 00.
        update("nt1", 32'h100, 1'b0, 1'b0, 32'h0, 1'b1, 32'h80, 1'b1, 32'h104);
        probe("nt1.after", 32'h100, 1'b0, 32'h80);
        update("nt2", 32'h100, 1'b0, 1'b0, 32'h0, 1'b0, 32'h80, 1'b0, 32'h104);
        update("nt3", 32'h100, 1'b0, 1'b0, 32'h0, 1'b0, 32'h80, 1'b0, 32'h104);
        // Going 00 -> 01 stays not-taken, which shows the 00 floor held.
        update("t1", 32'h100, 1'b0, 1'b1, 32'h80, 1'b0, 32'h80, 1'b1, 32'h80);
        probe("t1.after", 32'h100, 1'b0, 32'h80);
        update("t2", 32'h100, 1'b0, 1'b1, 32'h80, 1'b0, 32'h80, 1'b1, 32'h80);
        probe("t2.after", 32'h100, 1'b1, 32'h80);
        // 10 -> 11 -> 11 -> 11, then one not-taken step is still taken.
        update("t3", 32'h100, 1'b0, 1'b1, 32'h80, 1'b1, 32'h80, 1'b0, 32'h80);
        update("t4", 32'h100, 1'b0, 1'b1, 32'h80, 1'b1, 32'h80, 1'b0, 32'h80);
        update("t5", 32'h100, 1'b0, 1'b1, 32'h80, 1'b1, 32'h80, 1'b0, 32'h80);
        update("nt4", 32'h100, 1'b0, 1'b0, 32'h0, 1'b1, 32'h80, 1'b1, 32'h104);
        probe("nt4.after", 32'h100, 1'b1, 32'h80);
        update("nt5", 32'h100, 1'b0, 1'b0, 32'h0, 1'b1, 32'h80, 1'b1, 32'h104);
        probe("nt5.after", 32'h100, 1'b0, 32'h80);

        // An alias at the same index replaces the entry.
        update("alias", 32'h140, 1'b0, 1'b1, 32'h400, 1'b0, 32'h0, 1'b1, 32'h400);
        probe("alias.old", 32'h100, 1'b0, 32'h0);
        probe("alias.new", 32'h140, 1'b1, 32'h400);
        // A not-taken miss must not allocate.
        update("ntMiss", 32'h200, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h204);
        probe("ntMiss.keep", 32'h140, 1'b1, 32'h400);
        probe("ntMiss.none", 32'h200, 1'b0, 32'h0);

        // A jump hit with the wrong target sets ctr=11 and a new target.
        update("jmp", 32'h140, 1'b1, 1'b1, 32'h300, 1'b1, 32'h200, 1'b1, 32'h300);
        probe("jmp.after", 32'h140, 1'b1, 32'h300);
        update("jmpOk", 32'h140, 1'b0, 1'b1, 32'h300, 1'b1, 32'h300, 1'b0, 32'h300);
        update("jmpNt", 32'h140, 1'b0, 1'b0, 32'h0, 1'b1, 32'h300, 1'b1, 32'h144);
        probe("jmpNt.after", 32'h140, 1'b1, 32'h300);
        // A taken branch with the right direction but the wrong target.
        update("badTgt", 32'h140, 1'b0, 1'b1, 32'h380, 1'b1, 32'h300, 1'b1, 32'h380);
        // A jump miss allocates with ctr=11.
        update("jmpMiss", 32'h108, 1'b1, 1'b1, 32'h500, 1'b0, 32'h0, 1'b1, 32'h500);
        update("jmpMissNt", 32'h108, 1'b0, 1'b0, 32'h0, 1'b1, 32'h500, 1'b1, 32'h10C);
        probe("jmpMissNt.after", 32'h108, 1'b1, 32'h500);

        // PCE+4 wraps. Both outputs react even with UpdateE=0.
        @(negedge clk);
        PCE = 32'hFFFF_FFFC; TakenE = 1'b0; PredTakenE = 1'b1; UpdateE = 1'b0;
        #1;
        checkVal("wrap.redir", RedirectPCE, 32'h0);
        checkVal("wrap.mis", {31'b0, MispredictE}, 32'd0);

`ifdef BP_STATS_EN
        checkVal("stats.branchCnt", BranchCntE, 32'(expBranch));
        checkVal("stats.mispredCnt", MispredCntE, 32'(expMispred));
`endif

        // Asynchronous reset mid-cycle with valid entries.
        PCF = 32'h140;
        #1;
        checkVal("preAsync.taken", {31'b0, PredTakenF}, 32'd1);
        rst = 1'b1;
        #1;
        checkVal("async.taken", {31'b0, PredTakenF}, 32'd0);
        checkVal("async.target", PredTargetF, 32'd0);
`ifdef BP_STATS_EN
        checkVal("async.branchCnt", BranchCntE, 32'd0);
        checkVal("async.mispredCnt", MispredCntE, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        #1;
        probe("afterAsync", 32'h140, 1'b0, 32'h0);

        $display("Result: errors=%0d of %0d checks", errCnt, checkCnt);
        $finish;
    end

endmodule
